// File: rtl/tns_pkg.sv
// Shared constants and helpers for the 3C1S 12x12 bus code.
// A lane codeword is a 12-bit numeral whose bit i carries weight TNS_WEIGHT[i].
// Legal codewords never contain CODE_ILLEGAL_PAT (four adjacent ones).
package tns_pkg;

  localparam int LANES    = 9;
  localparam int CW_W     = 12;
  localparam int DATA_W   = 11;
  localparam int SUM_W    = 13;
  localparam int ERRCNT_W = 16;
  localparam int HALF_W   = CW_W / 2;

  // Each weight equals the number of legal codewords one bit shorter, so the
  // greedy encoding of any value never produces the illegal run.
  localparam logic [SUM_W-1:0] TNS_WEIGHT [0:CW_W-1] = '{
    13'd1,   13'd2,   13'd4,   13'd8,   13'd15,  13'd29,
    13'd56,  13'd108, 13'd208, 13'd401, 13'd773, 13'd1490
  };

  localparam int                      CODE_ILLEGAL_W   = 4;
  localparam logic [CODE_ILLEGAL_W-1:0] CODE_ILLEGAL_PAT = 4'b1111;

  // Weighted sum of one half-codeword; base is the bit index of its LSB.
  function automatic logic [SUM_W-1:0] partial_sum(input logic [HALF_W-1:0] bits,
                                                   input int                base);
    logic [SUM_W-1:0] s;
    s = '0;
    for (int i = 0; i < HALF_W; i++) begin
      if (bits[i]) s = s + TNS_WEIGHT[base+i];
    end
    return s;
  endfunction

  // True when the forbidden pattern appears at any bit offset.
  function automatic logic has_illegal(input logic [CW_W-1:0] cw);
    logic hit;
    hit = 1'b0;
    for (int off = 0; off <= CW_W - CODE_ILLEGAL_W; off++) begin
      if (cw[off +: CODE_ILLEGAL_W] == CODE_ILLEGAL_PAT) hit = 1'b1;
    end
    return hit;
  endfunction

endpackage

// File: rtl/TNS_decoder_12.sv
// One-lane TNS decoder: 12-bit codeword -> 11-bit data plus error flag.
// Three register stages, each carrying its own valid bit; data registers
// load only on a valid beat so idle cycles leave them untouched.
module TNS_decoder_12
  import tns_pkg::*;
(
  input  logic              clock,
  input  logic              rst_n,
  input  logic              in_valid,
  input  logic [CW_W-1:0]   codein,
  output logic              out_valid,
  output logic [DATA_W-1:0] dataout,
  output logic              err
);

  logic              r_v1;
  logic [CW_W-1:0]   r_cw1;
  logic              r_v2;
  logic [SUM_W-1:0]  r_lo2;
  logic [SUM_W-1:0]  r_hi2;
  logic              r_ill2;
  logic              r_v3;
  logic [DATA_W-1:0] r_data3;
  logic              r_err3;
  logic [SUM_W-1:0]  w_sum;

  assign w_sum = r_lo2 + r_hi2;

  // S1: capture the incoming codeword.
  always_ff @(posedge clock or negedge rst_n) begin
    // NOTE: data registers are reset as well so every output reads 0 during reset;
    // the hold-on-idle behaviour comes from the valid-qualified load, not from reset.
    if (!rst_n) begin
      r_v1  <= 1'b0;
      r_cw1 <= '0;
    end else begin
      // NOTE: non-blocking assignments keep every stage sampling the previous
      // stage's old value, which is what makes this a pipeline.
      r_v1 <= in_valid;
      if (in_valid) r_cw1 <= codein;
    end
  end

  // S2: partial sums over the low and high halves, plus the illegal-pattern scan.
  always_ff @(posedge clock or negedge rst_n) begin
    if (!rst_n) begin
      r_v2   <= 1'b0;
      r_lo2  <= '0;
      r_hi2  <= '0;
      r_ill2 <= 1'b0;
    end else begin
      r_v2 <= r_v1;
      if (r_v1) begin
        r_lo2  <= partial_sum(r_cw1[HALF_W-1:0], 0);
        r_hi2  <= partial_sum(r_cw1[CW_W-1:HALF_W], HALF_W);
        r_ill2 <= has_illegal(r_cw1);
      end
    end
  end

  // S3: final sum, range check, registered outputs.
  always_ff @(posedge clock or negedge rst_n) begin
    if (!rst_n) begin
      r_v3    <= 1'b0;
      r_data3 <= '0;
      r_err3  <= 1'b0;
    end else begin
      r_v3 <= r_v2;
      if (r_v2) begin
        r_data3 <= w_sum[DATA_W-1:0];
        r_err3  <= r_ill2 | (|w_sum[SUM_W-1:DATA_W]);
      end
    end
  end

  assign out_valid = r_v3;
  assign dataout   = r_data3;
  assign err       = r_err3;

endmodule

// File: rtl/decoder_3c1s_12x12.sv
// 3C1S 12x12 bus decoder: nine TNS lanes in parallel plus a saturating
// counter of output beats that carried at least one lane error.
// err_count reflects a flagged beat one cycle after it appears on the outputs.
module decoder_3c1s_12x12
  import tns_pkg::*;
(
  input  logic                    clock,
  input  logic                    rst_n,
  input  logic                    in_valid,
  input  logic [LANES*CW_W-1:0]   codein,
  input  logic                    err_clr,
  output logic                    out_valid,
  output logic [LANES*DATA_W-1:0] dataout,
  output logic [LANES-1:0]        lane_err,
  output logic [ERRCNT_W-1:0]     err_count
);

  logic [LANES-1:0]    w_valid;
  logic                w_any_err;
  logic                w_cnt_inc;
  logic [ERRCNT_W-1:0] r_err_count;

  for (genvar k = 0; k < LANES; k++) begin : g_lane
    TNS_decoder_12 u_lane (
      .clock     (clock),
      .rst_n     (rst_n),
      .in_valid  (in_valid),
      .codein    (codein[k*CW_W +: CW_W]),
      .out_valid (w_valid[k]),
      .dataout   (dataout[k*DATA_W +: DATA_W]),
      .err       (lane_err[k])
    );
  end

  // All lanes share one valid pipeline, so their valids are identical.
  assign out_valid = &w_valid;
  assign w_any_err = |lane_err;
  assign w_cnt_inc = out_valid & w_any_err & ~(&r_err_count);

  // Error counter: clear wins over increment; stops at all-ones.
  always_ff @(posedge clock or negedge rst_n) begin
    if (!rst_n)         r_err_count <= '0;
    else if (err_clr)   r_err_count <= '0;
    else if (w_cnt_inc) r_err_count <= r_err_count + 1'b1;
  end

  assign err_count = r_err_count;

endmodule

// File: tb/tb_decoder_3c1s_12x12.sv
// Self-checking bench for decoder_3c1s_12x12. The reference model decodes each
// beat arithmetically from the weight table, tracks the beat history by clock
// edge and keeps its own saturating error count.
module tb_decoder_3c1s_12x12;

  localparam int W [12] = '{1, 2, 4, 8, 15, 29, 56, 108, 208, 401, 773, 1490};

  logic          clock = 1'b0;
  logic          rst_n;
  logic          in_valid;
  logic [107:0]  codein;
  logic          err_clr;
  logic          out_valid;
  logic [98:0]   dataout;
  logic [8:0]    lane_err;
  logic [15:0]   err_count;

  int checks = 0;
  int errors = 0;

  // Reference model state: beats sampled at the last three edges (index 0 newest).
  bit            pv [3];
  logic [107:0]  pc [3];
  logic          m_ov;
  logic [98:0]   m_data;
  logic [8:0]    m_err;
  logic [15:0]   m_cnt;

  decoder_3c1s_12x12 dut (
    .clock     (clock),
    .rst_n     (rst_n),
    .in_valid  (in_valid),
    .codein    (codein),
    .err_clr   (err_clr),
    .out_valid (out_valid),
    .dataout   (dataout),
    .lane_err  (lane_err),
    .err_count (err_count)
  );

  always #5 clock = ~clock;

  initial begin
    #5_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  function automatic int tns_value(input logic [11:0] cw);
    int s = 0;
    for (int i = 0; i < 12; i++) if (cw[i]) s += W[i];
    return s;
  endfunction

  function automatic bit illegal(input logic [11:0] cw);
    int run = 0;
    bit bad = 1'b0;
    for (int i = 0; i < 12; i++) begin
      run = cw[i] ? run + 1 : 0;
      if (run >= 4) bad = 1'b1;
    end
    return bad;
  endfunction

  function automatic logic [11:0] encode(input int v);
    logic [11:0] cw = '0;
    int rem = v;
    for (int i = 11; i >= 0; i--) begin
      if (rem >= W[i]) begin
        cw[i] = 1'b1;
        rem -= W[i];
      end
    end
    return cw;
  endfunction

  task automatic check(input string tag, input logic [127:0] obs, input logic [127:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic check_all(input string tag);
    check({tag, ".out_valid"}, 128'(out_valid), 128'(m_ov));
    check({tag, ".dataout"},   128'(dataout),   128'(m_data));
    check({tag, ".lane_err"},  128'(lane_err),  128'(m_err));
    check({tag, ".err_count"}, 128'(err_count), 128'(m_cnt));
  endtask

  task automatic model_reset();
    for (int i = 0; i < 3; i++) begin
      pv[i] = 1'b0;
      pc[i] = '0;
    end
    m_ov   = 1'b0;
    m_data = '0;
    m_err  = '0;
    m_cnt  = '0;
  endtask

  // Advance one clock edge, update the model from the inputs seen at that edge,
  // then compare every output just after the edge.
  task automatic tick();
    logic [11:0] cw;
    int          s;
    @(posedge clock);
    if (err_clr) m_cnt = '0;
    else if (m_ov && m_err != 0 && m_cnt != 16'hFFFF) m_cnt = m_cnt + 16'd1;
    pv[2] = pv[1]; pc[2] = pc[1];
    pv[1] = pv[0]; pc[1] = pc[0];
    pv[0] = in_valid; pc[0] = codein;
    m_ov = pv[2];
    if (pv[2]) begin
      for (int k = 0; k < 9; k++) begin
        cw = pc[2][12*k +: 12];
        s  = tns_value(cw);
        m_data[11*k +: 11] = s[10:0];
        m_err[k] = (s > 2047) || illegal(cw);
      end
    end
    #1;
    check_all("stream");
  endtask

  task automatic drive_data(input logic [98:0] d);
    for (int k = 0; k < 9; k++) codein[12*k +: 12] = encode(int'(d[11*k +: 11]));
  endtask

  task automatic drive_random_legal();
    for (int k = 0; k < 9; k++) codein[12*k +: 12] = encode(int'($urandom_range(0, 2047)));
  endtask

  initial begin
    logic [98:0] d;
    bit          pat [5];

    rst_n = 1'b0; in_valid = 1'b0; err_clr = 1'b0; codein = '0;
    model_reset();
    #12;
    check_all("reset");
    @(negedge clock);
    rst_n = 1'b1;

    // 1: all-zero codewords, first output after the third edge.
    in_valid = 1'b1; codein = '0;
    tick(); tick(); tick();
    check("t1_out_valid", 128'(out_valid), 128'(1'b1));
    check("t1_dataout",   128'(dataout),   128'(0));
    check("t1_lane_err",  128'(lane_err),  128'(0));

    // 2: loopback of directed patterns and random data through the greedy encoder.
    d = '0;
    drive_data(d); tick();
    for (int i = 0; i < 99; i++) d[i] = (i % 2 == 0);
    drive_data(d); tick();
    d = '1;
    drive_data(d); tick();
    for (int n = 0; n < 1000; n++) begin
      drive_random_legal();
      tick();
    end
    // Raw random codewords with random valid: exercises error flags and hold.
    for (int n = 0; n < 300; n++) begin
      in_valid = ($urandom_range(0, 3) != 0);
      for (int k = 0; k < 9; k++) codein[12*k +: 12] = 12'($urandom);
      tick();
    end

    // 3: single error beat on lane 4.
    in_valid = 1'b0;
    repeat (3) tick();
    err_clr = 1'b1; tick();
    err_clr = 1'b0; tick();
    drive_random_legal();
    codein[48 +: 12] = 12'hFFF;
    in_valid = 1'b1; tick();
    in_valid = 1'b0; tick(); tick();
    check("t3_out_valid", 128'(out_valid),      128'(1'b1));
    check("t3_lane_err",  128'(lane_err),       128'(9'h010));
    check("t3_lane4_data", 128'(dataout[44 +: 11]), 128'(11'h417));
    tick();
    check("t3_err_count", 128'(err_count), 128'(16'd1));

    // 4: stream enough error beats to reach and hold saturation, then clear-vs-increment.
    err_clr = 1'b1; tick();
    err_clr = 1'b0;
    codein = '0;
    codein[11:0] = 12'hFFF;
    in_valid = 1'b1;
    repeat (65537) tick();
    in_valid = 1'b0;
    repeat (4) tick();
    check("t4_saturated", 128'(err_count), 128'(16'hFFFF));
    in_valid = 1'b1; tick();
    in_valid = 1'b0; tick(); tick();
    check("t4_err_beat", 128'(lane_err), 128'(9'h001));
    err_clr = 1'b1; tick();
    err_clr = 1'b0;
    check("t4_clr_priority", 128'(err_count), 128'(16'd0));

    // 5: asynchronous reset with two beats in flight.
    drive_random_legal();
    in_valid = 1'b1; tick();
    drive_random_legal();
    tick();
    in_valid = 1'b0;
    #2 rst_n = 1'b0;
    model_reset();
    #1;
    check_all("async_reset");
    @(posedge clock);
    @(negedge clock);
    rst_n = 1'b1;
    repeat (5) tick();
    check("t5_no_stale_valid", 128'(out_valid), 128'(1'b0));
    drive_random_legal();
    in_valid = 1'b1; tick();
    in_valid = 1'b0; tick(); tick();
    check("t5_new_beat", 128'(out_valid), 128'(1'b1));

    // 6: valid toggling 1,0,1,1,0 with fresh codewords every cycle.
    pat = '{1'b1, 1'b0, 1'b1, 1'b1, 1'b0};
    for (int i = 0; i < 5; i++) begin
      in_valid = pat[i];
      drive_random_legal();
      tick();
    end
    in_valid = 1'b0;
    repeat (4) tick();

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
